viterbi_frame_decoder: RTL and testbench
========================================

Name: viterbi_frame_decoder

Overview:
- Parametrised hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code used on the PCM link.
- Decodes one frame of FRAME_LEN information bits per pass, using valid/ready handshakes on both sides.
- Generalises the fixed 8-bit decoder: frame length and generator polynomials are parameters.
- Starts from the known all-zero encoder state, with no leading-'1' sync assumption, and delivers the decoded frame MSB-first.

Parameters:
- FRAME_LEN, 8: information bits per frame (2..64).
- G0, 3'b111: generator for conv_code[1]. Bit 2 taps u, bit 1 taps s[1], bit 0 taps s[0].
- G1, 3'b101: generator for conv_code[0], same tap mapping.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  conv_code holds a symbol.
- in_ready  output  1  decoder accepts a symbol this cycle.
- conv_code  input  2  received symbol {G0 bit, G1 bit}.
- out_valid  output  1  pcm holds a decoded frame.
- out_ready  input  1  consumer accepts the frame.
- pcm  output  FRAME_LEN  decoded frame; pcm[FRAME_LEN-1] is the first bit sent.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low. It forces the FSM to ACS.
  - Path metrics: PM[0]=0, PM[1..3]=INF (all ones).
  - Step counter 0; in_ready=1, out_valid=0, pcm=0.
  - Survivor memory is not cleared.
  - Reset mid-frame discards the frame silently.
- Trellis: state s={s[1],s[0]}, where s[1] is the most recent bit. Input u gives next state {u,s[1]}.
  - Expected symbol: bit1 = parity(G0 & {u,s}), bit0 = parity(G1 & {u,s}).
  - Branch metric = Hamming distance (0..2).
- PM_W localparam = clog2(2*NSYM+2), where NSYM = FRAME_LEN, or FRAME_LEN+2 with the tail feature. All additions saturate at INF.
- FSM states:
  - ACS:
    - in_ready=1. Each in_valid&&in_ready handshake runs one add-compare-select for all 4 states in a single cycle.
    - Predecessors of ns={u,a} are {a,0} and {a,1}.
    - Strictly smaller candidate wins; on a tie, predecessor {a,0} wins.
    - One decision bit per state is stored at survivor row step (row 0 = first symbol); then step increments.
    - in_valid low: metrics and step hold.
    - Handshake on step==NSYM-1: go to TB_INIT.
  - TB_INIT (1 cycle):
    - in_ready=0.
    - Choose the start state: minimum-PM state, lowest index on ties.
    - Set the traceback pointer to row NSYM-1.
  - TRACEBACK (NSYM cycles, one row per cycle):
    - Decoded bit of row r = s[1] of the current state.
    - Predecessor = {s[0], decision[r][s]}.
    - Bits for rows 0..FRAME_LEN-1 are written to pcm[FRAME_LEN-1-r]; tail rows are discarded.
    - After row 0: go to OUT.
  - OUT:
    - out_valid=1; pcm held stable.
    - On out_ready: out_valid=0, metrics reinitialised as at reset, step=0, go to ACS.
    - The next cycle may accept a symbol.
- Latency: out_valid rises NSYM+1 cycles after the last symbol handshake.
- No symbols are accepted from TB_INIT until the frame is consumed. Input stalls are tolerated between any symbols.

Optional Feature:
- Macro VITERBI_TAIL_FLUSH_EN.
- Defined:
  - NSYM = FRAME_LEN+2; the encoder appends two zero tail bits.
  - TB_INIT forces start state 0 regardless of metrics.
- Undefined:
  - NSYM = FRAME_LEN; traceback starts from the minimum-metric state.
  - The last one or two bits may be unreliable under errors.

Decomposition:
- Package viterbi_pkg holds:
  - FSM state enum {ACS, TB_INIT, TRACEBACK, OUT}.
  - NUM_STATES=4 and K=3.
  - A function computing the expected symbol from (u, s, G0, G1).
  - A saturating-add function.
- One sub-module: viterbi_acs_unit. It is combinational; it takes 4 PMs plus a symbol and returns 4 new PMs plus 4 decision bits. The top-level holds the FSM, survivor RAM and traceback.

Test Plan:
- Tail off, FRAME_LEN=8, error-free.
  - Stimulus: symbols 11,10,00,10,11,11,10,00 fed back-to-back.
  - Response: pcm=8'hA5, out_valid exactly 9 cycles after the last handshake.
- Tail on, FRAME_LEN=8.
  - Stimulus: the same symbols followed by 10,11, with symbol 3 corrupted 00→01 and symbol 6 corrupted 11→10.
  - Response: pcm=8'hA5.
- Backpressure.
  - Stimulus: in_valid toggled randomly during ACS; out_ready held low 5 cycles in OUT.
  - Response: pcm stable, in_ready=0 throughout OUT, a second frame of all-00 symbols decodes to 8'h00.
- Tie-break.
  - Stimulus: all-00 symbols with one 11 at symbol 0 (tail off).
  - Response: deterministic pcm=8'h00, matching the reference model's lower-predecessor rule.
- Reset mid-frame.
  - Stimulus: assert reset after 4 symbols, then send a full 0xA5 frame.
  - Response: pcm=8'hA5, no stale out_valid.
- FRAME_LEN=16, tail on.
  - Stimulus: an encoded frame of 16'hBEEF.
  - Response: pcm=16'hBEEF after 18 traceback-related cycles plus 1.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the K=3, rate-1/2 hard-decision Viterbi frame decoder.
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int K          = 3;
   // Widest path metric any legal FRAME_LEN (with tail) can need.
   localparam int PM_W_MAX   = 8;

   typedef enum logic [1:0] {
      ACS       = 2'd0,
      TB_INIT   = 2'd1,
      TRACEBACK = 2'd2,
      OUT       = 2'd3
   } vit_state_e;

   function automatic logic [1:0] expected_symbol(input logic       u,
                                                  input logic [1:0] s,
                                                  input logic [2:0] g0,
                                                  input logic [2:0] g1);
      logic [K-1:0] taps;
      taps = {u, s};
      return {^(g0 & taps), ^(g1 & taps)};
   endfunction

   function automatic logic [PM_W_MAX-1:0] sat_add(input logic [PM_W_MAX-1:0] a,
                                                   input logic [PM_W_MAX-1:0] b,
                                                   input logic [PM_W_MAX-1:0] inf);
      logic [PM_W_MAX:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum >= {1'b0, inf}) ? inf : sum[PM_W_MAX-1:0];
   endfunction

endpackage

// File: rtl/viterbi_frame_decoder_if.sv
// Symbol-in / frame-out bus of the Viterbi frame decoder.
// A transfer happens on a rising clk edge where valid and ready are both high;
// valid never waits for ready, and the payload is held while valid is high and ready low.
interface viterbi_frame_decoder_if #(
   parameter int FRAME_LEN = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           conv_code;
   logic                 out_valid;
   logic                 out_ready;
   logic [FRAME_LEN-1:0] pcm;

   modport master (
      output in_valid, conv_code, out_ready,
      input  in_ready, out_valid, pcm
   );

   modport slave (
      input  in_valid, conv_code, out_ready,
      output in_ready, out_valid, pcm
   );
endinterface

// File: rtl/viterbi_acs_unit.sv
// Combinational add-compare-select over all four trellis states for one received symbol.
module viterbi_acs_unit
   import viterbi_pkg::*;
#(
   parameter int         PM_W = 5,
   parameter logic [2:0] G0   = 3'b111,
   parameter logic [2:0] G1   = 3'b101
) (
   input  logic [NUM_STATES-1:0][PM_W-1:0] pm_i,
   input  logic [1:0]                      sym_i,
   output logic [NUM_STATES-1:0][PM_W-1:0] pm_o,
   output logic [NUM_STATES-1:0]           dec_o
);

   localparam logic [PM_W-1:0] INF = '1;

   logic [1:0]      nsv;
   logic [1:0]      p0;
   logic [1:0]      p1;
   logic [1:0]      x0;
   logic [1:0]      x1;
   logic [PM_W-1:0] c0;
   logic [PM_W-1:0] c1;

   always_comb begin
      pm_o  = '0;
      dec_o = '0;
      nsv   = '0;
      p0    = '0;
      p1    = '0;
      x0    = '0;
      x1    = '0;
      c0    = '0;
      c1    = '0;
      for (int ns = 0; ns < NUM_STATES; ns++) begin
         nsv = 2'(ns);
         // ns = {u, a} is reachable from {a, 0} and {a, 1}
         p0  = {nsv[0], 1'b0};
         p1  = {nsv[0], 1'b1};
         x0  = expected_symbol(nsv[1], p0, G0, G1) ^ sym_i;
         x1  = expected_symbol(nsv[1], p1, G0, G1) ^ sym_i;
         c0  = PM_W'(sat_add(PM_W_MAX'(pm_i[p0]), PM_W_MAX'({x0[1] & x0[0], x0[1] ^ x0[0]}),
                             PM_W_MAX'(INF)));
         c1  = PM_W'(sat_add(PM_W_MAX'(pm_i[p1]), PM_W_MAX'({x1[1] & x1[0], x1[1] ^ x1[0]}),
                             PM_W_MAX'(INF)));
         // Ties keep the {a,0} predecessor so decoding is deterministic
         if (c1 < c0) begin
            pm_o[ns]  = c1;
            dec_o[ns] = 1'b1;
         end else begin
            pm_o[ns]  = c0;
            dec_o[ns] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/viterbi_frame_decoder.sv
// Frame-based hard-decision Viterbi decoder (rate 1/2, K=3): ACS per symbol, then traceback.
// Optional tail flushing (two zero tail bits, traceback from state 0): define VITERBI_TAIL_FLUSH_EN.
module viterbi_frame_decoder
   import viterbi_pkg::*;
#(
   parameter int         FRAME_LEN = 8,
   parameter logic [2:0] G0        = 3'b111,
   parameter logic [2:0] G1        = 3'b101
) (
   input  logic                           clk,
   input  logic                           reset,
   viterbi_frame_decoder_if.slave         bus,
   output vit_state_e                     dbg_state_o
);

`ifdef VITERBI_TAIL_FLUSH_EN
   localparam int NSYM = FRAME_LEN + 2;
`else
   localparam int NSYM = FRAME_LEN;
`endif
   localparam int PM_W = $clog2(2 * NSYM + 2);
   localparam int AW   = $clog2(NSYM);

   localparam logic [PM_W-1:0] INF = '1;
   localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_INIT = {INF, INF, INF, {PM_W{1'b0}}};

   vit_state_e                      state_q;
   logic [NUM_STATES-1:0][PM_W-1:0] pm_q;
   logic [NUM_STATES-1:0][PM_W-1:0] pm_d;
   logic [NUM_STATES-1:0]           dec_d;
   logic [AW-1:0]                   step_q;
   logic [AW-1:0]                   tb_row_q;
   logic [1:0]                      tb_state_q;
   logic [FRAME_LEN-1:0]            pcm_q;
   logic                            in_ready_q;
   logic                            out_valid_q;
   logic [1:0]                      start_state;
   logic                            keep_row;
   logic                            acs_fire;

   // One decision bit per state per symbol; contents are never reset
   logic [NUM_STATES-1:0]           surv_q [NSYM];

   viterbi_acs_unit #(
      .PM_W (PM_W),
      .G0   (G0),
      .G1   (G1)
   ) u_acs (
      .pm_i  (pm_q),
      .sym_i (bus.conv_code),
      .pm_o  (pm_d),
      .dec_o (dec_d)
   );

   assign acs_fire = (state_q == ACS) && bus.in_valid && in_ready_q;

`ifdef VITERBI_TAIL_FLUSH_EN
   assign start_state = 2'd0;
   assign keep_row    = (tb_row_q < AW'(FRAME_LEN));
`else
   logic [PM_W-1:0] best_pm;

   always_comb begin
      start_state = 2'd0;
      best_pm     = pm_q[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (pm_q[i] < best_pm) begin
            best_pm     = pm_q[i];
            start_state = 2'(i);
         end
      end
   end

   assign keep_row = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (acs_fire) surv_q[step_q] <= dec_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACS;
         pm_q        <= PM_INIT;
         step_q      <= '0;
         tb_row_q    <= '0;
         tb_state_q  <= '0;
         pcm_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACS: begin
               if (acs_fire) begin
                  pm_q   <= pm_d;
                  step_q <= step_q + AW'(1);
                  if (step_q == AW'(NSYM - 1)) begin
                     state_q    <= TB_INIT;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            TB_INIT: begin
               tb_state_q <= start_state;
               tb_row_q   <= AW'(NSYM - 1);
               state_q    <= TRACEBACK;
            end
            TRACEBACK: begin
               // Rows come out last-first, so shifting right lands row 0 at the MSB
               if (keep_row) pcm_q <= {tb_state_q[1], pcm_q[FRAME_LEN-1:1]};
               tb_state_q <= {tb_state_q[0], surv_q[tb_row_q][tb_state_q]};
               if (tb_row_q == '0) begin
                  state_q     <= OUT;
                  out_valid_q <= 1'b1;
               end else begin
                  tb_row_q <= tb_row_q - AW'(1);
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  pm_q        <= PM_INIT;
                  step_q      <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ACS;
               end
            end
            default: state_q <= ACS;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.pcm       = pcm_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Directed bench for viterbi_frame_decoder: FRAME_LEN=8 and FRAME_LEN=16 instances share one stimulus path.
module tb_viterbi_frame_decoder;
   import viterbi_pkg::*;

`ifdef VITERBI_TAIL_FLUSH_EN
   localparam int TAIL = 2;
`else
   localparam int TAIL = 0;
`endif
   localparam int NSYM8  = 8 + TAIL;
   localparam int NSYM16 = 16 + TAIL;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       v;
   logic [1:0] code;
   logic       ordy;
   logic       sel;
   int         passed = 0;
   int         total  = 0;

   vit_state_e st8;
   vit_state_e st16;

   // Encoded 0xA5 followed by its two tail symbols
   logic [1:0] a5_syms [10] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11,
                                2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
   // Encoded 0xBEEF followed by its two tail symbols
   logic [1:0] beef_syms [18] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10,
                                  2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01,
                                  2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};

   viterbi_frame_decoder_if #(.FRAME_LEN(8))  if8  ();
   viterbi_frame_decoder_if #(.FRAME_LEN(16)) if16 ();

   viterbi_frame_decoder #(.FRAME_LEN(8)) dut8 (
      .clk         (clk),
      .reset       (reset_n),
      .bus         (if8),
      .dbg_state_o (st8)
   );

   viterbi_frame_decoder #(.FRAME_LEN(16)) dut16 (
      .clk         (clk),
      .reset       (reset_n),
      .bus         (if16),
      .dbg_state_o (st16)
   );

   always #5 clk = ~clk;

   assign if8.in_valid   = v & ~sel;
   assign if16.in_valid  = v & sel;
   assign if8.conv_code  = code;
   assign if16.conv_code = code;
   assign if8.out_ready  = ordy & ~sel;
   assign if16.out_ready = ordy & sel;

   logic        rdy;
   logic        ov;
   logic [15:0] pcm_m;
   assign rdy   = sel ? if16.in_ready  : if8.in_ready;
   assign ov    = sel ? if16.out_valid : if8.out_valid;
   assign pcm_m = sel ? if16.pcm : {8'h00, if8.pcm};

   task automatic do_reset();
      reset_n = 1'b0;
      v       = 1'b0;
      code    = 2'b00;
      ordy    = 1'b0;
      sel     = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic send_sym(input logic [1:0] s, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      v    = 1'b1;
      code = s;
      while (!rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", rdy, n);
         v = 1'b0;
      end else begin
         @(posedge clk);
         #1 v = 1'b0;
      end
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!ov && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic consume(input int hold, input string tag);
      logic [15:0] snap;
      snap = pcm_m;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         total++;
         if (pcm_m !== snap || rdy !== 1'b0 || ov !== 1'b1)
            $display("FAIL %s_hold: pcm=%h in_ready=%b out_valid=%b, required pcm=%h in_ready=0 out_valid=1",
                     tag, pcm_m, rdy, ov, snap);
         else passed++;
      end
      @(negedge clk);
      ordy = 1'b1;
      @(posedge clk);
      #1 ordy = 1'b0;
      total++;
      if (ov !== 1'b0 || rdy !== 1'b1)
         $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 and 1", tag, ov, rdy);
      else passed++;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if (if8.in_ready !== 1'b1 || if16.in_ready !== 1'b1)
         $display("FAIL reset_in_ready: got %b/%b, required 1/1", if8.in_ready, if16.in_ready);
      else passed++;
      total++;
      if (if8.out_valid !== 1'b0 || if16.out_valid !== 1'b0)
         $display("FAIL reset_out_valid: got %b/%b, required 0/0", if8.out_valid, if16.out_valid);
      else passed++;
      total++;
      if (if8.pcm !== 8'h00 || if16.pcm !== 16'h0000)
         $display("FAIL reset_pcm: got %h/%h, required 00/0000", if8.pcm, if16.pcm);
      else passed++;
      total++;
      if (st8 !== ACS || st16 !== ACS)
         $display("FAIL reset_state: got %0d/%0d, required %0d", st8, st16, ACS);
      else passed++;
   endtask

   task automatic test_error_free();
      int cyc;
      sel = 1'b0;
      for (int i = 0; i < NSYM8; i++) send_sym(a5_syms[i], 0);
      wait_out(cyc);
      total++;
      if (cyc !== NSYM8 + 1)
         $display("FAIL a5_latency: got %0d cycles, required %0d", cyc, NSYM8 + 1);
      else passed++;
      total++;
      if (pcm_m !== 16'h00A5) $display("FAIL a5_pcm: got %h, required 00a5", pcm_m);
      else passed++;
      consume(0, "a5");
   endtask

   task automatic test_error_correct();
      int         cyc;
      logic [1:0] s [10];
      sel  = 1'b0;
      s    = a5_syms;
      s[2] = 2'b01;
      s[5] = 2'b10;
      for (int i = 0; i < NSYM8; i++) send_sym(s[i], 0);
      wait_out(cyc);
      total++;
      if (pcm_m !== 16'h00A5) $display("FAIL corrected_pcm: got %h, required 00a5", pcm_m);
      else passed++;
      consume(0, "corrected");
   endtask

   task automatic test_backpressure();
      int cyc;
      sel = 1'b0;
      for (int i = 0; i < NSYM8; i++) send_sym(a5_syms[i], $urandom_range(0, 3));
      wait_out(cyc);
      total++;
      if (pcm_m !== 16'h00A5) $display("FAIL bp_pcm: got %h, required 00a5", pcm_m);
      else passed++;
      consume(5, "bp");
      for (int i = 0; i < NSYM8; i++) send_sym(2'b00, $urandom_range(0, 2));
      wait_out(cyc);
      total++;
      if (cyc !== NSYM8 + 1 || pcm_m !== 16'h0000)
         $display("FAIL bp_zero_frame: latency=%0d pcm=%h, required %0d and 0000", cyc, pcm_m, NSYM8 + 1);
      else passed++;
      consume(1, "bp_zero");
   endtask

   task automatic test_tie_break();
      int cyc;
      sel = 1'b0;
      send_sym(2'b11, 0);
      for (int i = 1; i < NSYM8; i++) send_sym(2'b00, 0);
      wait_out(cyc);
      total++;
      if (pcm_m !== 16'h0000) $display("FAIL tie_pcm: got %h, required 0000", pcm_m);
      else passed++;
      consume(0, "tie");
   endtask

   task automatic test_reset_mid_frame();
      int cyc;
      sel = 1'b0;
      for (int i = 0; i < 4; i++) send_sym(a5_syms[i], 0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (ov !== 1'b0 || rdy !== 1'b1 || st8 !== ACS)
         $display("FAIL midreset_state: out_valid=%b in_ready=%b state=%0d, required 0,1,%0d",
                  ov, rdy, st8, ACS);
      else passed++;
      for (int i = 0; i < NSYM8; i++) send_sym(a5_syms[i], 0);
      wait_out(cyc);
      total++;
      if (cyc !== NSYM8 + 1)
         $display("FAIL midreset_latency: got %0d cycles, required %0d", cyc, NSYM8 + 1);
      else passed++;
      total++;
      if (pcm_m !== 16'h00A5) $display("FAIL midreset_pcm: got %h, required 00a5", pcm_m);
      else passed++;
      consume(0, "midreset");
   endtask

   task automatic test_frame16();
      int cyc;
      sel = 1'b1;
      for (int i = 0; i < NSYM16; i++) send_sym(beef_syms[i], 0);
      wait_out(cyc);
      total++;
      if (cyc !== NSYM16 + 1)
         $display("FAIL beef_latency: got %0d cycles, required %0d", cyc, NSYM16 + 1);
      else passed++;
      total++;
      if (pcm_m !== 16'hBEEF) $display("FAIL beef_pcm: got %h, required beef", pcm_m);
      else passed++;
      consume(2, "beef");
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_error_free();
      test_error_correct();
      test_backpressure();
      test_tie_break();
      test_reset_mid_frame();
      test_frame16();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
